// File: rtl/ahb_bridge_arbiter.sv
// Round-robin arbiter/sequencer between the I2C-slave bridge (s0) and the local
// control path (s1) for a single shared AHB master user interface.
module ahb_bridge_arbiter #(
   parameter int unsigned ADDR_W         = 32,
   parameter int unsigned DATA_W         = 32,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              s0_w_valid_i,
   input  logic              s0_r_valid_i,
   input  logic [ADDR_W-1:0] s0_waddr_i,
   input  logic [ADDR_W-1:0] s0_raddr_i,
   input  logic [DATA_W-1:0] s0_wdata_i,
   output logic [DATA_W-1:0] s0_rdata_o,
   output logic              s0_done_o,
   output logic              s0_err_o,
   input  logic              s1_w_valid_i,
   input  logic              s1_r_valid_i,
   input  logic [ADDR_W-1:0] s1_waddr_i,
   input  logic [ADDR_W-1:0] s1_raddr_i,
   input  logic [DATA_W-1:0] s1_wdata_i,
   output logic [DATA_W-1:0] s1_rdata_o,
   output logic              s1_done_o,
   output logic              s1_err_o,
   output logic [ADDR_W-1:0] m_waddr_o,
   output logic [ADDR_W-1:0] m_raddr_o,
   output logic [DATA_W-1:0] m_wdata_o,
   output logic              m_w_valid_o,
   output logic              m_r_valid_o,
   input  logic [DATA_W-1:0] m_rdata_i,
   input  logic              m_done_i,
   output logic              busy_o,
   output logic              grant_o
);

   localparam int unsigned CNT_W = 16;
   localparam bit                TO_EN   = (TIMEOUT_CYCLES != 0);
   localparam logic [CNT_W-1:0]  TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_e;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                grant_q, grant_d;
   logic                wr_q, wr_d;
   logic [ADDR_W-1:0]   m_waddr_q, m_waddr_d;
   logic [ADDR_W-1:0]   m_raddr_q, m_raddr_d;
   logic [DATA_W-1:0]   m_wdata_q, m_wdata_d;
   logic                m_w_valid_q, m_w_valid_d;
   logic                m_r_valid_q, m_r_valid_d;
   logic [DATA_W-1:0]   s0_rdata_q, s0_rdata_d;
   logic [DATA_W-1:0]   s1_rdata_q, s1_rdata_d;
   logic                s0_done_q, s0_done_d;
   logic                s1_done_q, s1_done_d;
   logic                s0_err_q, s0_err_d;
   logic                s1_err_q, s1_err_d;
   logic                busy_q, busy_d;

   logic                pend0_c, pend1_c, sel_c, sel_wr_c;

   assign pend0_c = s0_w_valid_i | s0_r_valid_i;
   assign pend1_c = s1_w_valid_i | s1_r_valid_i;

   // On a tie, the requester not granted last time wins.
   always_comb begin
      sel_c = 1'b0;
      if (pend0_c && pend1_c) begin
         sel_c = ~grant_q;
      end else if (pend1_c) begin
         sel_c = 1'b1;
      end
      sel_wr_c = sel_c ? s1_w_valid_i : s0_w_valid_i;
   end

   // Next-state and registered-output logic.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      grant_d     = grant_q;
      wr_d        = wr_q;
      m_waddr_d   = m_waddr_q;
      m_raddr_d   = m_raddr_q;
      m_wdata_d   = m_wdata_q;
      m_w_valid_d = 1'b0;
      m_r_valid_d = 1'b0;
      s0_rdata_d  = s0_rdata_q;
      s1_rdata_d  = s1_rdata_q;
      s0_done_d   = 1'b0;
      s1_done_d   = 1'b0;
      s0_err_d    = 1'b0;
      s1_err_d    = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (pend0_c || pend1_c) begin
               grant_d     = sel_c;
               wr_d        = sel_wr_c;
               m_waddr_d   = sel_c ? s1_waddr_i : s0_waddr_i;
               m_raddr_d   = sel_c ? s1_raddr_i : s0_raddr_i;
               m_wdata_d   = sel_c ? s1_wdata_i : s0_wdata_i;
               m_w_valid_d = sel_wr_c;
               m_r_valid_d = ~sel_wr_c;
               state_d     = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            cnt_d   = '0;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (m_done_i) begin
               if (!wr_q) begin
                  if (grant_q) s1_rdata_d = m_rdata_i;
                  else         s0_rdata_d = m_rdata_i;
               end
               s0_done_d = ~grant_q;
               s1_done_d = grant_q;
               state_d   = ST_RESP;
            end else if (TO_EN && (cnt_q == TO_LAST)) begin
               s0_done_d = ~grant_q;
               s1_done_d = grant_q;
               s0_err_d  = ~grant_q;
               s1_err_d  = grant_q;
               state_d   = ST_RESP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         grant_q     <= 1'b1;
         wr_q        <= 1'b0;
         m_waddr_q   <= '0;
         m_raddr_q   <= '0;
         m_wdata_q   <= '0;
         m_w_valid_q <= 1'b0;
         m_r_valid_q <= 1'b0;
         s0_rdata_q  <= '0;
         s1_rdata_q  <= '0;
         s0_done_q   <= 1'b0;
         s1_done_q   <= 1'b0;
         s0_err_q    <= 1'b0;
         s1_err_q    <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         grant_q     <= grant_d;
         wr_q        <= wr_d;
         m_waddr_q   <= m_waddr_d;
         m_raddr_q   <= m_raddr_d;
         m_wdata_q   <= m_wdata_d;
         m_w_valid_q <= m_w_valid_d;
         m_r_valid_q <= m_r_valid_d;
         s0_rdata_q  <= s0_rdata_d;
         s1_rdata_q  <= s1_rdata_d;
         s0_done_q   <= s0_done_d;
         s1_done_q   <= s1_done_d;
         s0_err_q    <= s0_err_d;
         s1_err_q    <= s1_err_d;
         busy_q      <= busy_d;
      end
   end

   assign s0_rdata_o  = s0_rdata_q;
   assign s1_rdata_o  = s1_rdata_q;
   assign s0_done_o   = s0_done_q;
   assign s1_done_o   = s1_done_q;
   assign s0_err_o    = s0_err_q;
   assign s1_err_o    = s1_err_q;
   assign m_waddr_o   = m_waddr_q;
   assign m_raddr_o   = m_raddr_q;
   assign m_wdata_o   = m_wdata_q;
   assign m_w_valid_o = m_w_valid_q;
   assign m_r_valid_o = m_r_valid_q;
   assign busy_o      = busy_q;
   assign grant_o     = grant_q;

endmodule

// File: tb/tb_ahb_bridge_arbiter.sv
// Randomized bench for ahb_bridge_arbiter against a transaction-level model of
// arbitration order, strobe/done latency, timeout and read-data return.
module tb_ahb_bridge_arbiter;

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned TO = 8;

   logic          clk = 1'b0;
   logic          rst_i;
   logic          s_wv [2];
   logic          s_rv [2];
   logic [AW-1:0] s_waddr [2];
   logic [AW-1:0] s_raddr [2];
   logic [DW-1:0] s_wdata [2];
   logic [DW-1:0] s0_rdata_o, s1_rdata_o;
   logic          s0_done_o, s1_done_o, s0_err_o, s1_err_o;
   logic [AW-1:0] m_waddr_o, m_raddr_o;
   logic [DW-1:0] m_wdata_o;
   logic          m_w_valid_o, m_r_valid_o;
   logic [DW-1:0] m_rdata_i;
   logic          m_done_i;
   logic          busy_o, grant_o;

   int n_checks = 0;
   int n_errors = 0;

   // Model state: who won last and what each requester should see on rdata.
   int            last_grant;
   logic [DW-1:0] rdata_exp [2];

   always #5 clk = ~clk;

   ahb_bridge_arbiter #(
      .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk_i(clk), .rst_i(rst_i),
      .s0_w_valid_i(s_wv[0]), .s0_r_valid_i(s_rv[0]),
      .s0_waddr_i(s_waddr[0]), .s0_raddr_i(s_raddr[0]), .s0_wdata_i(s_wdata[0]),
      .s0_rdata_o(s0_rdata_o), .s0_done_o(s0_done_o), .s0_err_o(s0_err_o),
      .s1_w_valid_i(s_wv[1]), .s1_r_valid_i(s_rv[1]),
      .s1_waddr_i(s_waddr[1]), .s1_raddr_i(s_raddr[1]), .s1_wdata_i(s_wdata[1]),
      .s1_rdata_o(s1_rdata_o), .s1_done_o(s1_done_o), .s1_err_o(s1_err_o),
      .m_waddr_o(m_waddr_o), .m_raddr_o(m_raddr_o), .m_wdata_o(m_wdata_o),
      .m_w_valid_o(m_w_valid_o), .m_r_valid_o(m_r_valid_o),
      .m_rdata_i(m_rdata_i), .m_done_i(m_done_i),
      .busy_o(busy_o), .grant_o(grant_o)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   function automatic bit any_pending();
      return s_wv[0] || s_rv[0] || s_wv[1] || s_rv[1];
   endfunction

   // Raise a fresh request (write, read or both) on idle requesters.
   task automatic refill(input bit force_all);
      for (int k = 0; k < 2; k++) begin
         if (!(s_wv[k] || s_rv[k]) && (force_all || $urandom_range(0, 2) != 0)) begin
            automatic int t = $urandom_range(0, 2);
            s_wv[k]    = (t != 1);
            s_rv[k]    = (t != 0);
            s_waddr[k] = $urandom;
            s_raddr[k] = $urandom;
            s_wdata[k] = $urandom;
         end
      end
   endtask

   // Called at the start of an IDLE cycle with requests already applied.
   // d_in: WAIT-cycle index of m_done_i (>= TO means no done before timeout; <0 random).
   task automatic run_txn(input int d_in, input logic [DW-1:0] rd);
      int win, d, exp_rel, seen;
      bit wr, ok, p0, p1;
      p0 = s_wv[0] || s_rv[0];
      p1 = s_wv[1] || s_rv[1];
      if (p0 && p1) win = (last_grant == 0) ? 1 : 0;
      else          win = p0 ? 0 : 1;
      wr      = s_wv[win];
      d       = (d_in < 0) ? int'($urandom_range(0, TO)) : d_in;
      ok      = (d < int'(TO));
      exp_rel = ok ? d + 3 : int'(TO) + 2;

      @(negedge clk);
      check("idle_busy", 64'(busy_o), 64'(0));
      check("idle_no_done", 64'(s0_done_o | s1_done_o), 64'(0));
      next_cycle();
      @(negedge clk);
      check("strobe_w", 64'(m_w_valid_o), 64'(wr));
      check("strobe_r", 64'(m_r_valid_o), 64'(!wr));
      check("grant", 64'(grant_o), 64'(win));
      check("m_waddr", 64'(m_waddr_o), 64'(s_waddr[win]));
      check("m_raddr", 64'(m_raddr_o), 64'(s_raddr[win]));
      check("m_wdata", 64'(m_wdata_o), 64'(s_wdata[win]));
      check("busy", 64'(busy_o), 64'(1));

      seen = 0;
      for (int rel = 2; rel <= int'(TO) + 4 && seen == 0; rel++) begin
         next_cycle();
         m_done_i  = (rel == d + 2);
         m_rdata_i = (rel == d + 2) ? rd : DW'($urandom);
         @(negedge clk);
         if (rel == 2) check("strobe_one_cycle", 64'(m_w_valid_o | m_r_valid_o), 64'(0));
         if (s0_done_o || s1_done_o) seen = rel;
      end

      check("done_cycle", 64'(seen), 64'(exp_rel));
      check("done_win", 64'(win ? s1_done_o : s0_done_o), 64'(1));
      check("done_other", 64'(win ? s0_done_o : s1_done_o), 64'(0));
      check("err_win", 64'(win ? s1_err_o : s0_err_o), 64'(!ok));
      check("err_other", 64'(win ? s0_err_o : s1_err_o), 64'(0));
      if (ok && !wr) rdata_exp[win] = rd;
      check("s0_rdata", 64'(s0_rdata_o), 64'(rdata_exp[0]));
      check("s1_rdata", 64'(s1_rdata_o), 64'(rdata_exp[1]));
      last_grant = win;

      next_cycle();
      m_done_i = 1'b0;
      if (wr) s_wv[win] = 1'b0;
      else    s_rv[win] = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 8 && any_pending(); i++) run_txn(-1, $urandom);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_i     = 1'b1;
      m_done_i  = 1'b0;
      m_rdata_i = '0;
      for (int k = 0; k < 2; k++) begin
         s_wv[k] = 1'b0; s_rv[k] = 1'b0;
         s_waddr[k] = '0; s_raddr[k] = '0; s_wdata[k] = '0;
         rdata_exp[k] = '0;
      end
      last_grant = 1;
      repeat (2) @(posedge clk);
      #1;
      rst_i = 1'b0;
      @(negedge clk);
      check("rst_busy", 64'(busy_o), 64'(0));
      check("rst_grant", 64'(grant_o), 64'(1));
      check("rst_strobes", 64'({m_w_valid_o, m_r_valid_o}), 64'(0));
      check("rst_maddr", 64'({m_waddr_o, m_raddr_o}), 64'(0));
      check("rst_mwdata", 64'(m_wdata_o), 64'(0));
      check("rst_done_err", 64'({s0_done_o, s1_done_o, s0_err_o, s1_err_o}), 64'(0));
      check("rst_rdata", 64'({s0_rdata_o, s1_rdata_o}), 64'(0));

      // Directed s0 write, done 3 cycles after the strobe.
      next_cycle();
      s_wv[0] = 1'b1; s_waddr[0] = 32'h0300_0018; s_wdata[0] = 32'h1234_5678;
      run_txn(2, $urandom);

      // Directed s1 read, data held afterwards.
      s_rv[1] = 1'b1; s_raddr[1] = 32'h0300_0018;
      run_txn(1, 32'hCAFE_F00D);
      repeat (3) next_cycle();
      @(negedge clk);
      check("s1_rdata_held", 64'(s1_rdata_o), 64'(32'hCAFE_F00D));
      next_cycle();

      // Same requester with write and read: write first, then the held read.
      s_wv[0] = 1'b1; s_rv[0] = 1'b1;
      s_waddr[0] = $urandom; s_raddr[0] = $urandom; s_wdata[0] = $urandom;
      run_txn(3, $urandom);
      run_txn(3, $urandom);

      // Both requesters continuously pending.
      for (int i = 0; i < 6; i++) begin
         refill(1'b1);
         run_txn(-1, $urandom);
      end
      drain();

      // Timeout, stray done in IDLE, then a clean read.
      s_rv[0] = 1'b1; s_raddr[0] = $urandom;
      run_txn(TO, $urandom);
      m_done_i = 1'b1; m_rdata_i = $urandom;
      next_cycle();
      m_done_i = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("stray_no_done", 64'(s0_done_o | s1_done_o | busy_o), 64'(0));
         next_cycle();
      end
      s_rv[0] = 1'b1; s_raddr[0] = $urandom;
      run_txn(4, $urandom);

      // Reset during WAIT, then a late done.
      s_wv[0] = 1'b1; s_waddr[0] = $urandom; s_wdata[0] = $urandom;
      next_cycle();
      next_cycle();
      @(negedge clk);
      check("pre_rst_busy", 64'(busy_o), 64'(1));
      next_cycle();
      rst_i = 1'b1; s_wv[0] = 1'b0;
      next_cycle();
      rst_i = 1'b0; m_done_i = 1'b1;
      last_grant = 1; rdata_exp[0] = '0; rdata_exp[1] = '0;
      @(negedge clk);
      check("post_rst_busy", 64'(busy_o), 64'(0));
      check("post_rst_grant", 64'(grant_o), 64'(1));
      for (int i = 0; i < 3; i++) begin
         check("post_rst_no_done", 64'(s0_done_o | s1_done_o), 64'(0));
         next_cycle();
         m_done_i = 1'b0;
         @(negedge clk);
      end
      next_cycle();
      refill(1'b1);
      run_txn(-1, $urandom);

      // Random traffic.
      for (int i = 0; i < 40; i++) begin
         refill(1'b0);
         if (!any_pending()) refill(1'b1);
         run_txn(-1, $urandom);
      end
      drain();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
